// File: rtl/div_fx_seq.sv
// Sequential restoring divider giving a fixed-point quotient A*2^S/B as {Q,F},
// with an optional two's-complement mode, divide-by-zero and saturation flags.
module div_fx_seq #(
  parameter int M      = 8,
  parameter int S      = 8,
  parameter int SIGNED = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st,
  input  logic [M-1:0] A,
  input  logic [S-1:0] B,
  output logic         busy,
  output logic         ok_div,
  output logic [M-1:0] Q,
  output logic [S-1:0] F,
  output logic         dz,
  output logic         ovf,
  output logic [1:0]   dbg_state
);

  localparam int W  = M + S;
  localparam int RW = M + 2 * S;
  localparam int CW = $clog2(W + 1);

  localparam logic [W-1:0] ALL_ONES = '1;
  localparam logic [W-1:0] MAX_POS  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [RW-1:0] rem;
  logic [RW-1:0] dvr;
  logic [W-1:0]  qf;
  logic [CW-1:0] cnt;
  logic          a_neg;
  logic          r_neg;
  logic          b_zero;

  logic          accept;
  logic          iterate;
  logic          q_bit;
  logic          a_neg_in;
  logic          b_neg_in;
  logic [M-1:0]  a_mag;
  logic [S-1:0]  b_mag;
  logic [W-1:0]  res;
  logic          res_ovf;

  // Handshake: st is taken only while idle (busy=0); ok_div pulses for one
  // cycle alongside the new result, and st may be raised in that same cycle.
  assign accept   = st && (state == IDLE);
  assign iterate  = (state == LOAD) || (state == ITER);
  assign busy     = (state != IDLE);
  assign dbg_state = state;

  assign a_neg_in = (SIGNED != 0) && A[M-1];
  assign b_neg_in = (SIGNED != 0) && B[S-1];
  assign a_mag    = a_neg_in ? (~A + 1'b1) : A;
  assign b_mag    = b_neg_in ? (~B + 1'b1) : B;

  assign q_bit    = (rem >= dvr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // LOAD is resident for one cycle and already retires the first quotient
  // bit, so LOAD + ITER together perform exactly M+S iterations.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (st) state_nx = LOAD;
      LOAD: state_nx = ITER;
      ITER: if (cnt == CW'(W - 1)) state_nx = FIN;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem    <= '0;
      dvr    <= '0;
      qf     <= '0;
      cnt    <= '0;
      a_neg  <= 1'b0;
      r_neg  <= 1'b0;
      b_zero <= 1'b0;
    end else if (accept) begin
      rem    <= RW'(a_mag) << S;
      dvr    <= RW'(b_mag) << (W - 1);
      qf     <= '0;
      cnt    <= '0;
      a_neg  <= a_neg_in;
      r_neg  <= a_neg_in ^ b_neg_in;
      b_zero <= (B == '0);
    end else if (iterate) begin
      rem <= q_bit ? (rem - dvr) : rem;
      dvr <= dvr >> 1;
      qf  <= {qf[W-2:0], q_bit};
      if (cnt != CW'(W)) cnt <= cnt + 1'b1;
    end
  end

  // A positive magnitude can reach 2^(W-1) only for A=-2^(M-1), B=-1.
  always_comb begin
    res     = qf;
    res_ovf = 1'b0;
    if (b_zero) begin
      if (SIGNED != 0) res = a_neg ? MIN_NEG : MAX_POS;
      else             res = ALL_ONES;
    end else if (SIGNED != 0) begin
      if (r_neg) begin
        res = ~qf + 1'b1;
      end else if (qf[W-1]) begin
        res     = MAX_POS;
        res_ovf = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ok_div <= 1'b0;
      Q      <= '0;
      F      <= '0;
      dz     <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      ok_div <= (state == FIN);
      if (state == FIN) begin
        {Q, F} <= res;
        dz     <= b_zero;
        ovf    <= res_ovf;
      end
    end
  end

endmodule

// File: tb/tb_div_fx_seq.sv
// Bench for div_fx_seq: directed 8/8 unsigned and signed scenarios plus a
// lockstep random regression on 6/10 and 12/4 instances against a model.
`timescale 1ns/1ps
module tb_div_fx_seq;

  // Both random configurations have M+S=16, so latency is 17 for all.
  localparam int LAT = 17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // directed instances: index 0 unsigned 8/8, index 1 signed 8/8
  logic [1:0]  dst, dbusy, dok, ddz, dovf;
  logic [15:0] dab [2];
  logic [15:0] dqf [2];
  logic [1:0]  dstate [2];

  // random instances: 0 = 6/10 u, 1 = 6/10 s, 2 = 12/4 u, 3 = 12/4 s
  logic [3:0]  rst_go, rbusy, rok, rdz, rovf;
  logic [15:0] rab [4];
  logic [15:0] rqf [4];
  logic [1:0]  rstate [4];

  logic [17:0] exp_q [$];
  logic [71:0] rexp_q [$];
  int          rstart_q [$];

  div_fx_seq #(.M(8), .S(8), .SIGNED(0)) u_u8 (
    .clk(clk), .rst_n(rst_n), .st(dst[0]), .A(dab[0][15:8]), .B(dab[0][7:0]),
    .busy(dbusy[0]), .ok_div(dok[0]), .Q(dqf[0][15:8]), .F(dqf[0][7:0]),
    .dz(ddz[0]), .ovf(dovf[0]), .dbg_state(dstate[0]));

  div_fx_seq #(.M(8), .S(8), .SIGNED(1)) u_s8 (
    .clk(clk), .rst_n(rst_n), .st(dst[1]), .A(dab[1][15:8]), .B(dab[1][7:0]),
    .busy(dbusy[1]), .ok_div(dok[1]), .Q(dqf[1][15:8]), .F(dqf[1][7:0]),
    .dz(ddz[1]), .ovf(dovf[1]), .dbg_state(dstate[1]));

  div_fx_seq #(.M(6), .S(10), .SIGNED(0)) u_u6 (
    .clk(clk), .rst_n(rst_n), .st(rst_go[0]), .A(rab[0][15:10]), .B(rab[0][9:0]),
    .busy(rbusy[0]), .ok_div(rok[0]), .Q(rqf[0][15:10]), .F(rqf[0][9:0]),
    .dz(rdz[0]), .ovf(rovf[0]), .dbg_state(rstate[0]));

  div_fx_seq #(.M(6), .S(10), .SIGNED(1)) u_s6 (
    .clk(clk), .rst_n(rst_n), .st(rst_go[1]), .A(rab[1][15:10]), .B(rab[1][9:0]),
    .busy(rbusy[1]), .ok_div(rok[1]), .Q(rqf[1][15:10]), .F(rqf[1][9:0]),
    .dz(rdz[1]), .ovf(rovf[1]), .dbg_state(rstate[1]));

  div_fx_seq #(.M(12), .S(4), .SIGNED(0)) u_u12 (
    .clk(clk), .rst_n(rst_n), .st(rst_go[2]), .A(rab[2][15:4]), .B(rab[2][3:0]),
    .busy(rbusy[2]), .ok_div(rok[2]), .Q(rqf[2][15:4]), .F(rqf[2][3:0]),
    .dz(rdz[2]), .ovf(rovf[2]), .dbg_state(rstate[2]));

  div_fx_seq #(.M(12), .S(4), .SIGNED(1)) u_s12 (
    .clk(clk), .rst_n(rst_n), .st(rst_go[3]), .A(rab[3][15:4]), .B(rab[3][3:0]),
    .busy(rbusy[3]), .ok_div(rok[3]), .Q(rqf[3][15:4]), .F(rqf[3][3:0]),
    .dz(rdz[3]), .ovf(rovf[3]), .dbg_state(rstate[3]));

  // Reference: {dz, ovf, {Q,F}} for an M+S=16 configuration, v = {A,B}.
  function automatic logic [17:0] model(input int m, input int s, input bit sg,
                                        input logic [15:0] v);
    longint sa, sb, qv;
    logic [15:0] r;
    logic dzf, ov;
    sa = longint'(v >> s);
    sb = longint'(v & ((16'd1 << s) - 16'd1));
    if (sg) begin
      if (sa >= (longint'(1) << (m - 1))) sa = sa - (longint'(1) << m);
      if (sb >= (longint'(1) << (s - 1))) sb = sb - (longint'(1) << s);
    end
    dzf = 1'b0;
    ov  = 1'b0;
    if (sb == 0) begin
      dzf = 1'b1;
      if (!sg)        r = 16'hFFFF;
      else if (sa < 0) r = 16'h8000;
      else            r = 16'h7FFF;
    end else begin
      qv = (sa * (longint'(1) << s)) / sb;
      if (sg && qv > 32767) begin
        r  = 16'h7FFF;
        ov = 1'b1;
      end else begin
        r = 16'(qv);
      end
    end
    return {dzf, ov, r};
  endfunction

  // Starts one operation on directed instance d from a negedge and returns
  // at the negedge where ok_div is seen (lat = edges after the start edge),
  // or with lat=-1 once limit cycles pass.
  task automatic drive_op(input int d, input logic [7:0] a, input logic [7:0] b,
                          input int pulse_at, input int abort_at, input int limit,
                          output int lat, output int busy_cnt,
                          output logic [17:0] got, output logic [1:0] st0);
    int k;
    dab[d] = {a, b};
    dst[d] = 1'b1;
    @(negedge clk);
    dst[d]   = 1'b0;
    st0      = dstate[d];
    k        = 0;
    lat      = -1;
    busy_cnt = 0;
    got      = '0;
    while (k < limit) begin
      if (dbusy[d] === 1'b1) busy_cnt++;
      if (dok[d] === 1'b1) begin
        lat = k;
        got = {ddz[d], dovf[d], dqf[d]};
        break;
      end
      if (k == pulse_at) begin
        dst[d] = 1'b1;
        dab[d] = 16'($urandom());
      end
      if (k == abort_at) rst_n = 1'b0;
      @(negedge clk);
      dst[d] = 1'b0;
      rst_n  = 1'b1;
      k++;
    end
  endtask

  task automatic test_reset();
    logic [3:0] bad;
    rst_n  = 1'b0;
    dst    = '0;
    rst_go = '0;
    for (int i = 0; i < 2; i++) dab[i] = '0;
    for (int i = 0; i < 4; i++) rab[i] = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({dbusy[d], dok[d], ddz[d], dovf[d], dqf[d], dstate[d]} !== 22'h0) begin
        errors++;
        $display("FAIL reset[%0d]: got busy=%b ok=%b dz=%b ovf=%b qf=%h state=%0d expected all 0",
                 d, dbusy[d], dok[d], ddz[d], dovf[d], dqf[d], dstate[d]);
      end
    end
    bad = '0;
    for (int i = 0; i < 4; i++)
      if ({rbusy[i], rok[i], rdz[i], rovf[i], rqf[i], rstate[i]} !== 22'h0) bad[i] = 1'b1;
    checks++;
    if (bad !== 4'h0) begin
      errors++;
      $display("FAIL reset random instances: got nonzero mask %b expected 0000", bad);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    int lat, bc;
    logic [17:0] got, e;
    logic [1:0] s0;
    exp_q.push_back(18'h00E49);
    drive_op(0, 8'd100, 8'd7, -1, -1, 40, lat, bc, got, s0);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL unsigned 100/7: got %h expected %h", got, e); end
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL unsigned latency: got %0d expected %0d", lat, LAT); end
    checks++;
    if (bc != LAT) begin errors++; $display("FAIL unsigned busy cycles: got %0d expected %0d", bc, LAT); end
    checks++;
    if (s0 !== 2'd1) begin errors++; $display("FAIL state after accept: got %0d expected 1", s0); end
    @(negedge clk);
    checks++;
    if (dok[0] !== 1'b0) begin errors++; $display("FAIL ok_div pulse width: got %b expected 0", dok[0]); end
    checks++;
    if (dqf[0] !== 16'h0E49) begin errors++; $display("FAIL result hold: got %h expected 0e49", dqf[0]); end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    logic [17:0] got, e;
    logic [1:0] s0;
    exp_q.push_back(18'h2FFFF);
    drive_op(0, 8'd5, 8'd0, -1, -1, 40, lat, bc, got, s0);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL unsigned 5/0: got %h expected %h", got, e); end
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL div-zero latency: got %0d expected %0d", lat, LAT); end
    checks++;
    if (dok[0] !== 1'b1) begin errors++; $display("FAIL back-to-back ok_div: got %b expected 1", dok[0]); end
    exp_q.push_back(18'h00100);
    drive_op(0, 8'd255, 8'd255, -1, -1, 40, lat, bc, got, s0);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL back-to-back 255/255: got %h expected %h", got, e); end
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL back-to-back latency: got %0d expected %0d", lat, LAT); end
  endtask

  task automatic test_signed();
    int lat, bc;
    logic [17:0] got, e;
    logic [1:0] s0;
    logic [15:0] ops [5];
    logic [17:0] exps [5];
    ops  = '{16'hF902, 16'h07FD, 16'h8000, 16'h8001, 16'h80FF};
    exps = '{18'h0FC80, 18'h0FDAB, 18'h28000, 18'h08000, 18'h17FFF};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(exps[i]);
      drive_op(1, ops[i][15:8], ops[i][7:0], -1, -1, 40, lat, bc, got, s0);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL signed %h/%h: got %h expected %h", ops[i][15:8], ops[i][7:0], got, e);
      end
      checks++;
      if (lat != LAT) begin errors++; $display("FAIL signed[%0d] latency: got %0d expected %0d", i, lat, LAT); end
    end
  endtask

  task automatic test_ignored_start();
    int lat, bc;
    logic [17:0] got, e;
    logic [1:0] s0;
    exp_q.push_back(18'h00E49);
    drive_op(0, 8'd100, 8'd7, 5, -1, 40, lat, bc, got, s0);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL ignored start result: got %h expected %h", got, e); end
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL ignored start latency: got %0d expected %0d", lat, LAT); end
    checks++;
    if (bc != LAT) begin errors++; $display("FAIL ignored start busy cycles: got %0d expected %0d", bc, LAT); end
  endtask

  task automatic test_reset_abort();
    int lat, bc;
    logic [17:0] got;
    logic [1:0] s0;
    @(negedge clk);
    drive_op(0, 8'd100, 8'd7, -1, 10, 31, lat, bc, got, s0);
    checks++;
    if (lat != -1) begin errors++; $display("FAIL abort ok_div seen: got latency %0d expected none", lat); end
    checks++;
    if (dbusy[0] !== 1'b0) begin errors++; $display("FAIL abort busy: got %b expected 0", dbusy[0]); end
    checks++;
    if ({ddz[0], dovf[0], dqf[0]} !== 18'h0) begin
      errors++;
      $display("FAIL abort outputs: got %h expected 0", {ddz[0], dovf[0], dqf[0]});
    end
    checks++;
    if (dqf[1] !== 16'h0) begin errors++; $display("FAIL abort clears signed result: got %h expected 0", dqf[1]); end
  endtask

  task automatic test_random();
    logic [71:0] e;
    logic [15:0] v, bm;
    int s;
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < 4; i++) begin
        s  = (i < 2) ? 10 : 4;
        bm = 16'((32'd1 << s) - 1);
        v  = 16'($urandom());
        case ($urandom_range(0, 7))
          0: v = v & ~bm;
          1: v = 16'h8000 | bm;
          2: v = v & bm;
          default: ;
        endcase
        rab[i] = v;
        e[18*i +: 18] = model(16 - s, s, (i % 2) == 1, v);
      end
      rexp_q.push_back(e);
      rstart_q.push_back(cyc);
      rst_go = 4'hF;
      @(negedge clk);
      rst_go = 4'h0;
      rab[0] = 16'($urandom());
      repeat (LAT) @(negedge clk);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (rexp_q.size() != 0) begin
      errors++;
      $display("FAIL random results outstanding: got %0d expected 0", rexp_q.size());
    end
  endtask

  logic [71:0] mon_e;
  int          mon_s;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (|rok) === 1'b1) begin
      checks++;
      if (rok !== 4'hF) begin errors++; $display("FAIL random ok_div alignment: got %b expected 1111", rok); end
      if (rexp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL random unexpected ok_div: got %b expected none", rok);
      end else begin
        mon_e = rexp_q.pop_front();
        mon_s = rstart_q.pop_front();
        checks++;
        if (cyc - mon_s - 1 != LAT) begin
          errors++;
          $display("FAIL random latency: got %0d expected %0d", cyc - mon_s - 1, LAT);
        end
        for (int i = 0; i < 4; i++) begin
          checks++;
          if ({rdz[i], rovf[i], rqf[i]} !== mon_e[18*i +: 18]) begin
            errors++;
            $display("FAIL random inst%0d: got %h expected %h", i, {rdz[i], rovf[i], rqf[i]},
                     mon_e[18*i +: 18]);
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_unsigned();
    test_div_zero();
    test_signed();
    test_ignored_start();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
